wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter for the physical register file. Collects results from four execution sources, each behind a small per-source queue, and drives the register file's three write ports (`waddr1..3`/`wdata1..3`/`we1..3`). Up to three writes issue per cycle, granted round-robin. Sits between the execution units and the 6-read/3-write register file.

## Interface

Parameters:
- `ADDR_LEN`, default `` `ADDR_LEN `` (6): physical register tag width (64 entries).
- `DATA_LEN`, default `` `DATA_LEN `` (32): result width.
- `QDEPTH`, default 2: entries per source queue. Power of two, at least 2.

Ports:
- `clk` in 1: single clock, all state on posedge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `flush` in 1: synchronous, discards all queued results (mispredict recovery).
- `src_valid[i]` in 1 (i=0..3): source i presents a result.
- `src_ready[i]` out 1: source i queue can accept; handshake completes when `src_valid[i] && src_ready[i]` at posedge.
- `src_tag[i]` in ADDR_LEN: destination physical register.
- `src_data[i]` in DATA_LEN: result value.
- `waddr1..3` out ADDR_LEN: write address per port, registered.
- `wdata1..3` out DATA_LEN: write data per port, registered.
- `we1..3` out 1: write enable per port, registered.

## Operation

- Reset values: `we1..3`=0, `waddr1..3`=0, `wdata1..3`=0, all queues empty, `rr_ptr`=0, `src_ready`=1 for all sources.
- Each source queue is a FIFO of {tag, data} with a read pointer, a write pointer and a count. Pointers wrap modulo QDEPTH.
- `src_ready[i]` = (count[i] < QDEPTH). It depends only on registered count, with no same-cycle dequeue credit.
- Grant, combinational each cycle:
  - Scan sources in order rr_ptr, rr_ptr+1, ... (mod 4).
  - Pick the first up to three with a non-empty queue.
  - Assign them to ports 1, 2, 3 in scan order.
  - Dequeue one head per granted source. A source gets at most one grant per cycle.
- Outputs: at posedge, port k takes the head {tag, data} of its granted source with `we`=1. Ports without a grant get `we`=0; their addr/data hold previous values.
- `rr_ptr` update: when at least one grant, becomes (last granted source + 1) mod 4. Otherwise unchanged.
- Simultaneous enqueue and dequeue on one queue: count unchanged, both pointers advance. Legal only when count ≥ 1.
- `flush`=1 at posedge:
  - All counts and pointers go to 0 and `we1..3` go to 0.
  - Enqueues in that cycle are dropped; no grants are taken.
  - `rr_ptr` is preserved.
- Same-cycle duplicate tags from different sources are illegal, because rename guarantees unique tags. There is no ordering guarantee between sources.
- Per-source order is always preserved.

## Timing

- Accept at posedge t → earliest `we`=1 with that tag after posedge t+1 → register file write at posedge t+2.
- Minimum latency is 2 cycles from handshake to a committed register file write.
- Throughput: 3 writes/cycle aggregate. One per source per cycle.
- A queue fills only under contention, when more than 3 sources are non-empty.
- `src_ready` falls in the cycle after count reaches QDEPTH. It rises the cycle after a dequeue without a paired enqueue.
- Reset mid-stream: outputs drop to 0 asynchronously and queued entries are lost. After reset is released, the first accept follows the normal latency.
- `flush` together with `reset`: reset dominates.

## Structure

- Shared package/header (constants.vh): `ADDR_LEN`, `DATA_LEN`, `NUM_WB_SRC`=4, `NUM_WR_PORTS`=3.
- One sub-module, `wb_src_queue`: a parameterized FIFO with enq/deq/flush, count, head output and ready. It is instantiated 4 times.
- The grant logic is a rotate / priority-pick / rotate-back network inside `wb_arbiter`.

## Test plan

- Single write: src0 sends tag 5, data 0xDEADBEEF at t → after t+1, `we1`=1, `waddr1`=5, `wdata1`=0xDEADBEEF; `we2`=`we3`=0. `rr_ptr` becomes 1.
- Four-way contention: all sources valid at t with tags 1..4, rr_ptr=0 → next cycle, ports 1/2/3 carry tags 1/2/3. The following cycle, port1 carries tag 4 and `rr_ptr` becomes 0.
- Per-source ordering: src2 sends tag 10 then tag 11 in consecutive cycles, others idle → `we1` with tag 10, then `we1` with tag 11, on successive cycles.
- Backpressure: all four sources stream continuously for 20 cycles.
  - At least one `src_ready` deasserts.
  - Scoreboard: no result lost or duplicated, and per-source order holds.
  - Exactly 3 writes in every steady-state cycle.
- Flush: queues hold 5 entries total, `flush`=1 for one cycle → `we1..3`=0 next cycle, all `src_ready`=1, and no flushed tag ever appears on a write port.
- Reset mid-stream: assert `reset` between clock edges while `we1`=1 → `we1..3`, `waddr`, `wdata` go to 0 immediately. After release, a new src3 write lands on port1 at normal latency.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Widths here are the defaults; wb_arbiter may override them through parameters.
package wb_arbiter_pkg;
  localparam int ADDR_LEN     = 6;
  localparam int DATA_LEN     = 32;
  localparam int NUM_WB_SRC   = 4;
  localparam int NUM_WR_PORTS = 3;
  localparam int SRC_IDX_W    = $clog2(NUM_WB_SRC);

  typedef logic [SRC_IDX_W-1:0] src_idx_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Bus between the execution-unit result sources and the register-file write ports.
// master = the source / register-file side; slave = the arbiter.
interface wb_arbiter_if #(
  parameter int ADDR_LEN = wb_arbiter_pkg::ADDR_LEN,
  parameter int DATA_LEN = wb_arbiter_pkg::DATA_LEN
);
  import wb_arbiter_pkg::*;

  logic [NUM_WB_SRC-1:0] src_valid;
  logic [NUM_WB_SRC-1:0] src_ready;
  logic [ADDR_LEN-1:0]   src_tag  [NUM_WB_SRC];
  logic [DATA_LEN-1:0]   src_data [NUM_WB_SRC];

  logic [ADDR_LEN-1:0]   waddr1, waddr2, waddr3;
  logic [DATA_LEN-1:0]   wdata1, wdata2, wdata3;
  logic                  we1, we2, we3;

  modport master (
    output src_valid, src_tag, src_data,
    input  src_ready,
    input  waddr1, waddr2, waddr3, wdata1, wdata2, wdata3, we1, we2, we3
  );

  modport slave (
    input  src_valid, src_tag, src_data,
    output src_ready,
    output waddr1, waddr2, waddr3, wdata1, wdata2, wdata3, we1, we2, we3
  );
endinterface

// File: rtl/wb_src_queue.sv
// Per-source result FIFO: circular buffer with read/write pointers and an occupancy count.
// QDEPTH must be a power of two so the pointers wrap naturally.
module wb_src_queue #(
  parameter int WIDTH  = 38,
  parameter int QDEPTH = 2,
  localparam int PTR_W = $clog2(QDEPTH),
  localparam int CNT_W = $clog2(QDEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             enq,
  input  logic             deq,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             ready
);
  logic [WIDTH-1:0] mem [QDEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;

  // NOTE: non-blocking assignments for all state, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; count alone decides which slots hold live entries.
  always_ff @(posedge clk) begin
    if (enq && !flush) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign ready = (count < CNT_W'(QDEPTH));
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: four source queues feed three registered register-file write
// ports, granted round-robin starting at rr_ptr, at most one grant per source per cycle.
module wb_arbiter #(
  parameter int ADDR_LEN = wb_arbiter_pkg::ADDR_LEN,
  parameter int DATA_LEN = wb_arbiter_pkg::DATA_LEN,
  parameter int QDEPTH   = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  wb_arbiter_if.slave   bus
);
  import wb_arbiter_pkg::*;

  localparam int ENTRY_W = ADDR_LEN + DATA_LEN;
  localparam int CNT_W   = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [ADDR_LEN-1:0] tag;
    logic [DATA_LEN-1:0] data;
  } entry_t;

  entry_t                  head   [NUM_WB_SRC];
  logic [CNT_W-1:0]        count  [NUM_WB_SRC];
  logic [NUM_WB_SRC-1:0]   nonempty;
  logic [NUM_WB_SRC-1:0]   grant;

  src_idx_t                rr_ptr, rr_next, scan_src;
  src_idx_t                port_src [NUM_WR_PORTS];
  logic [NUM_WR_PORTS-1:0] port_vld;
  logic [1:0]              n_grant;

  entry_t                  wr_q [NUM_WR_PORTS];
  logic [NUM_WR_PORTS-1:0] we_q;

  for (genvar i = 0; i < NUM_WB_SRC; i++) begin : g_src
    wb_src_queue #(.WIDTH(ENTRY_W), .QDEPTH(QDEPTH)) u_queue (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .enq   (bus.src_valid[i] && bus.src_ready[i]),
      .deq   (grant[i]),
      .din   ({bus.src_tag[i], bus.src_data[i]}),
      .head  (head[i]),
      .count (count[i]),
      .ready (bus.src_ready[i])
    );
    assign nonempty[i] = (count[i] != '0);
  end

  // Rotate by rr_ptr, pick the first three non-empty sources, map each back to its index.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    grant    = '0;
    port_vld = '0;
    rr_next  = rr_ptr;
    scan_src = '0;
    n_grant  = '0;
    for (int k = 0; k < NUM_WR_PORTS; k++) port_src[k] = '0;
    if (!flush) begin
      for (int j = 0; j < NUM_WB_SRC; j++) begin
        scan_src = rr_ptr + src_idx_t'(j);
        if (nonempty[scan_src] && n_grant < 2'(NUM_WR_PORTS)) begin
          port_src[n_grant] = scan_src;
          port_vld[n_grant] = 1'b1;
          grant[scan_src]   = 1'b1;
          rr_next           = scan_src + src_idx_t'(1);
          n_grant           = n_grant + 2'd1;
        end
      end
    end
  end

  // Idle ports keep their last address/data; only the enable drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      we_q   <= '0;
      for (int k = 0; k < NUM_WR_PORTS; k++) wr_q[k] <= '0;
    end else begin
      rr_ptr <= rr_next;
      we_q   <= port_vld;
      for (int k = 0; k < NUM_WR_PORTS; k++) begin
        if (port_vld[k]) wr_q[k] <= head[port_src[k]];
      end
    end
  end

  assign bus.we1    = we_q[0];
  assign bus.we2    = we_q[1];
  assign bus.we3    = we_q[2];
  assign bus.waddr1 = wr_q[0].tag;
  assign bus.waddr2 = wr_q[1].tag;
  assign bus.waddr3 = wr_q[2].tag;
  assign bus.wdata1 = wr_q[0].data;
  assign bus.wdata2 = wr_q[1].data;
  assign bus.wdata3 = wr_q[2].data;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based model of the round-robin writeback rules.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int QD = 2;

  typedef struct packed {
    logic [ADDR_LEN-1:0] tag;
    logic [DATA_LEN-1:0] data;
  } item_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  wb_arbiter_if bus ();

  wb_arbiter #(.QDEPTH(QD)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [ADDR_LEN-1:0] o_addr [NUM_WR_PORTS];
  logic [DATA_LEN-1:0] o_data [NUM_WR_PORTS];
  logic                o_we   [NUM_WR_PORTS];
  assign o_addr[0] = bus.waddr1;
  assign o_addr[1] = bus.waddr2;
  assign o_addr[2] = bus.waddr3;
  assign o_data[0] = bus.wdata1;
  assign o_data[1] = bus.wdata2;
  assign o_data[2] = bus.wdata3;
  assign o_we[0]   = bus.we1;
  assign o_we[1]   = bus.we2;
  assign o_we[2]   = bus.we3;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: contents of each source queue, scan start, and the write-port registers.
  item_t               mq [NUM_WB_SRC][$];
  int                  rr;
  logic [ADDR_LEN-1:0] m_addr [NUM_WR_PORTS];
  logic [DATA_LEN-1:0] m_data [NUM_WR_PORTS];
  logic                m_we   [NUM_WR_PORTS];
  int                  last_writes;
  logic [ADDR_LEN-1:0] next_tag = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 1'b0;
    for (int i = 0; i < NUM_WB_SRC; i++) begin
      bus.src_valid[i] = 1'b0;
      bus.src_tag[i]   = '0;
      bus.src_data[i]  = '0;
    end
  endtask

  task automatic put(input int s, input logic [ADDR_LEN-1:0] t, input logic [DATA_LEN-1:0] d);
    bus.src_valid[s] = 1'b1;
    bus.src_tag[s]   = t;
    bus.src_data[s]  = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_WB_SRC; i++) mq[i].delete();
    rr = 0;
    for (int k = 0; k < NUM_WR_PORTS; k++) begin
      m_addr[k] = '0;
      m_data[k] = '0;
      m_we[k]   = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < NUM_WR_PORTS; k++) begin
      check($sformatf("%s_we%0d", tag, k + 1), 64'(o_we[k]), 64'(0));
      check($sformatf("%s_waddr%0d", tag, k + 1), 64'(o_addr[k]), 64'(0));
      check($sformatf("%s_wdata%0d", tag, k + 1), 64'(o_data[k]), 64'(0));
    end
  endtask

  // Called just after a negedge with inputs driven; advances one clock and checks outputs.
  task automatic cycle();
    logic  rdy [NUM_WB_SRC];
    item_t it;
    int    n, last, s;
    for (int i = 0; i < NUM_WB_SRC; i++) begin
      rdy[i] = (mq[i].size() < QD);
      check($sformatf("ready%0d", i), 64'(bus.src_ready[i]), 64'(rdy[i]));
    end
    for (int k = 0; k < NUM_WR_PORTS; k++) m_we[k] = 1'b0;
    if (flush) begin
      for (int i = 0; i < NUM_WB_SRC; i++) mq[i].delete();
    end else begin
      n    = 0;
      last = 0;
      for (int j = 0; j < NUM_WB_SRC; j++) begin
        s = (rr + j) % NUM_WB_SRC;
        if (mq[s].size() != 0 && n < NUM_WR_PORTS) begin
          it        = mq[s].pop_front();
          m_we[n]   = 1'b1;
          m_addr[n] = it.tag;
          m_data[n] = it.data;
          last      = s;
          n++;
        end
      end
      if (n > 0) rr = (last + 1) % NUM_WB_SRC;
      for (int i = 0; i < NUM_WB_SRC; i++) begin
        if (bus.src_valid[i] && rdy[i]) mq[i].push_back({bus.src_tag[i], bus.src_data[i]});
      end
    end
    @(posedge clk);
    #1;
    last_writes = 0;
    for (int k = 0; k < NUM_WR_PORTS; k++) begin
      check($sformatf("we%0d", k + 1), 64'(o_we[k]), 64'(m_we[k]));
      check($sformatf("waddr%0d", k + 1), 64'(o_addr[k]), 64'(m_addr[k]));
      check($sformatf("wdata%0d", k + 1), 64'(o_data[k]), 64'(m_data[k]));
      if (o_we[k]) last_writes++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    check_zero("reset");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic put_next(input int s);
    put(s, next_tag, $urandom);
    next_tag = next_tag + 1'b1;
  endtask

  initial begin
    logic saw_not_ready;
    idle_inputs();
    model_reset();

    @(negedge clk);
    check_zero("por");
    check("por_ready", 64'(bus.src_ready), 64'(4'hF));
    reset = 1'b0;

    // Single write, then confirm the scan now starts at source 1.
    put(0, 6'd5, 32'hDEADBEEF);
    cycle();
    idle_inputs();
    cycle();
    check("single_we1", 64'(bus.we1), 64'(1));
    check("single_waddr1", 64'(bus.waddr1), 64'(5));
    check("single_wdata1", 64'(bus.wdata1), 64'(32'hDEADBEEF));
    check("single_we23", 64'({bus.we2, bus.we3}), 64'(0));
    put(0, 6'd20, 32'h20);
    put(1, 6'd21, 32'h21);
    cycle();
    idle_inputs();
    cycle();
    check("rr1_port1", 64'(bus.waddr1), 64'(21));
    check("rr1_port2", 64'(bus.waddr2), 64'(20));

    // Four-way contention from rr_ptr = 0.
    do_reset();
    for (int i = 0; i < NUM_WB_SRC; i++) put(i, ADDR_LEN'(i + 1), DATA_LEN'(32'h100 + i));
    cycle();
    idle_inputs();
    cycle();
    check("c4_port1", 64'(bus.waddr1), 64'(1));
    check("c4_port2", 64'(bus.waddr2), 64'(2));
    check("c4_port3", 64'(bus.waddr3), 64'(3));
    cycle();
    check("c4_tail_port1", 64'(bus.waddr1), 64'(4));
    check("c4_tail_we", 64'({bus.we1, bus.we2, bus.we3}), 64'(3'b100));
    put(0, 6'd40, 32'h40);
    put(1, 6'd41, 32'h41);
    cycle();
    idle_inputs();
    cycle();
    check("c4_rr0_port1", 64'(bus.waddr1), 64'(40));

    // Per-source ordering.
    do_reset();
    put(2, 6'd10, 32'hA);
    cycle();
    put(2, 6'd11, 32'hB);
    cycle();
    check("order_first", 64'(bus.waddr1), 64'(10));
    idle_inputs();
    cycle();
    check("order_second", 64'(bus.waddr1), 64'(11));
    check("order_second_we", 64'(bus.we1), 64'(1));

    // Backpressure: every source streams for 20 cycles.
    do_reset();
    saw_not_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < NUM_WB_SRC; i++) put_next(i);
      if (bus.src_ready != 4'hF) saw_not_ready = 1'b1;
      cycle();
      if (c >= 1) check("bp_writes", 64'(last_writes), 64'(3));
    end
    check("bp_ready_drop", 64'(saw_not_ready), 64'(1));
    idle_inputs();
    for (int c = 0; c < 6; c++) cycle();

    // Flush with five entries queued; an enqueue in the flush cycle is dropped.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM_WB_SRC; i++) put_next(i);
      cycle();
    end
    idle_inputs();
    flush = 1'b1;
    put(1, 6'd50, 32'h50);
    cycle();
    check("flush_we", 64'({bus.we1, bus.we2, bus.we3}), 64'(0));
    idle_inputs();
    check("flush_ready", 64'(bus.src_ready), 64'(4'hF));
    for (int c = 0; c < 3; c++) cycle();

    // Asynchronous reset while port 1 is writing.
    do_reset();
    put(0, 6'd7, 32'h77);
    cycle();
    idle_inputs();
    cycle();
    check("mid_pre_we1", 64'(bus.we1), 64'(1));
    reset = 1'b1;
    #1;
    check_zero("mid");
    model_reset();
    #1;
    reset = 1'b0;
    put(3, 6'd9, 32'h12345678);
    cycle();
    idle_inputs();
    cycle();
    check("mid_after_we1", 64'(bus.we1), 64'(1));
    check("mid_after_waddr1", 64'(bus.waddr1), 64'(9));
    check("mid_after_wdata1", 64'(bus.wdata1), 64'(32'h12345678));

    // Random traffic with occasional flushes.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      for (int i = 0; i < NUM_WB_SRC; i++) begin
        if ($urandom_range(3) != 0) put_next(i);
      end
      flush = ($urandom_range(24) == 0);
      cycle();
    end
    idle_inputs();
    for (int c = 0; c < 6; c++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
